// File: rtl/std_cache_pkg.sv
// Shared cache-side types: store-buffer entry layout, defaults and the byte-lane merge helper.
package std_cache_pkg;

  localparam int STD_SB_DEPTH  = 8;
  localparam int STD_SB_ADDR_W = 56;

  typedef struct packed {
    logic                     valid;
    logic [STD_SB_ADDR_W-4:0] addr;
    logic [63:0]              data;
    logic [7:0]               be;
  } sb_entry_t;

  // Overlay the enabled byte lanes of a younger store onto an existing entry.
  function automatic sb_entry_t sb_merge(input sb_entry_t e, input logic [63:0] d,
                                         input logic [7:0] be);
    sb_entry_t r;
    r = e;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        r.data[b*8 +: 8] = d[b*8 +: 8];
        r.be[b]          = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/std_sb_match.sv
// DEPTH-way page-offset comparator: flags any valid entry whose addr[11:3] equals the load's.
module std_sb_match #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [DEPTH-1:0][8:0] off_i,
  input  logic [8:0]            ld_off_i,
  output logic                  conflict_o
);

  always_comb begin
    conflict_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (off_i[i] == ld_off_i)) conflict_o = 1'b1;
    end
  end

endmodule

// File: rtl/std_store_buffer.sv
// In-order committed-store buffer draining oldest-first to the L1 store port.
// Optional youngest-entry coalescing is built only when STD_SB_COALESCE_EN is defined.
module std_store_buffer
  import std_cache_pkg::*;
#(
  parameter int DEPTH      = STD_SB_DEPTH,
  parameter int ADDR_WIDTH = STD_SB_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  flush_ack_o,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [63:0]           st_data_i,
  input  logic [7:0]            st_be_i,
  output logic                  dc_req_o,
  input  logic                  dc_gnt_i,
  output logic [ADDR_WIDTH-1:0] dc_addr_o,
  output logic [63:0]           dc_wdata_o,
  output logic [7:0]            dc_be_o,
  input  logic [8:0]            ld_off_i,
  output logic                  ld_conflict_o,
  output logic                  empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ADDR_WIDTH - 3;

  sb_entry_t       ent_q [DEPTH];
  sb_entry_t       ent_d [DEPTH];
  sb_entry_t       new_ent;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            flush_ack_q, flush_ack_d, flush_done_q;
  logic            push, pop, merge_en;
  logic [DEPTH-1:0]      vld_vec;
  logic [DEPTH-1:0][8:0] off_vec;
  logic            unused_addr_lo;

  assign unused_addr_lo = ^st_addr_i[2:0];

  assign empty_o     = (count_q == '0);
  assign st_ready_o  = (count_q != CW'(DEPTH));
  assign dc_req_o    = !empty_o;
  assign flush_ack_o = flush_ack_q;

  assign push = st_valid_i && st_ready_o && (st_be_i != 8'h00);
  assign pop  = dc_req_o && dc_gnt_i;

`ifdef STD_SB_COALESCE_EN
  logic [PW-1:0] tail_m1;
  assign tail_m1 = tail_q - PW'(1);
  // With two or more entries the youngest is never the head on the port, so it is safe to modify.
  assign merge_en = (count_q >= CW'(2)) &&
                    (ent_q[tail_m1].addr[AW-1:0] == st_addr_i[ADDR_WIDTH-1:3]);
`else
  assign merge_en = 1'b0;
`endif

  always_comb begin
    new_ent              = '0;
    new_ent.valid        = 1'b1;
    new_ent.addr[AW-1:0] = st_addr_i[ADDR_WIDTH-1:3];
    new_ent.data         = st_data_i;
    new_ent.be           = st_be_i;
  end

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d  = head_q + PW'(1);
      count_d = count_d - CW'(1);
    end
    if (push && !merge_en) begin
      ent_d[tail_q] = new_ent;
      tail_d  = tail_q + PW'(1);
      count_d = count_d + CW'(1);
    end
`ifdef STD_SB_COALESCE_EN
    if (push && merge_en) ent_d[tail_m1] = sb_merge(ent_q[tail_m1], st_data_i, st_be_i);
`endif
    // Ack fires once, on the cycle the buffer becomes (or is seen) empty under a flush.
    flush_ack_d = flush_i && (count_d == '0) && !flush_done_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_ack_q  <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      flush_ack_q  <= flush_ack_d;
      flush_done_q <= flush_i && (flush_done_q || flush_ack_d);
    end
  end

  assign dc_addr_o  = empty_o ? '0 : {ent_q[head_q].addr[AW-1:0], 3'b000};
  assign dc_wdata_o = empty_o ? '0 : ent_q[head_q].data;
  assign dc_be_o    = empty_o ? '0 : ent_q[head_q].be;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_vec[i] = ent_q[i].valid;
      off_vec[i] = ent_q[i].addr[8:0];
    end
  end

  std_sb_match #(.DEPTH(DEPTH)) u_match (
    .valid_i    (vld_vec),
    .off_i      (off_vec),
    .ld_off_i   (ld_off_i),
    .conflict_o (ld_conflict_o)
  );

endmodule
